// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the multi-precision CLA add/subtract sequencer.
package cla_seq_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word-index width; at least one bit even for degenerate word counts.
  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/cla_16bits.sv
// 16-bit carry-lookahead adder slice: four 4-bit groups with a second lookahead
// level across groups. cout is the carry out of bit 15.
module cla_16bits
  import cla_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [3:0]         gg;
  logic [3:0]         gp;
  logic [4:0]         gc;
  logic [SLICE_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
  end

  // Group carries come straight from the group terms rather than rippling.
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  // NOTE: every bit of c is assigned on every pass, so no latch is inferred.
  always_comb begin
    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    c[SLICE_W] = gc[4];
  end

  assign sum  = p ^ c[SLICE_W-1:0];
  assign cout = c[SLICE_W];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-precision add/subtract sequencer: one shared 16-bit CLA slice, one word
// per cycle, LSW first. Define CLA_SEQ_OVF_EN to compute signed overflow.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = SLICE_W,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORDS*WIDTH-1:0] op_a,
  input  logic [WORDS*WIDTH-1:0] op_b,
  input  logic                   sub,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORDS*WIDTH-1:0] result,
  output logic                   cout,
  output logic                   ovf
);

  localparam int IW = idx_w(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_t          state;
  logic [IW-1:0]   idx;
  logic            c;
  logic            sub_q;
  logic [WIDTH-1:0] a_word [WORDS];
  logic [WIDTH-1:0] b_word [WORDS];
  logic [WIDTH-1:0] r_word [WORDS];

  logic [WIDTH-1:0] slice_a;
  logic [WIDTH-1:0] slice_b;
  logic [WIDTH-1:0] slice_s;
  logic             slice_co;
  logic             accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // Subtraction is A + ~B with the carry register preloaded to ~borrow-in.
  assign slice_a = a_word[idx];
  assign slice_b = b_word[idx] ^ {WIDTH{sub_q}};

  cla_16bits u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (c),
    .sum  (slice_s),
    .cout (slice_co)
  );

  // NOTE: operand storage carries no reset; it is only read after an accept
  // has loaded it. The result array does reset, because result is visible.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < WORDS; i++) begin
        a_word[i] <= op_a[i*WIDTH +: WIDTH];
        b_word[i] <= op_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      c     <= 1'b0;
      sub_q <= 1'b0;
      cout  <= 1'b0;
      for (int i = 0; i < WORDS; i++) r_word[i] <= '0;
`ifdef CLA_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sub_q <= sub;
            c     <= cin ^ sub;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          r_word[idx] <= slice_s;
          c           <= slice_co;
          if (idx == LAST) begin
            cout  <= slice_co;
`ifdef CLA_SEQ_OVF_EN
            ovf   <= (slice_s[WIDTH-1] ^ slice_a[WIDTH-1] ^ slice_b[WIDTH-1]) ^ slice_co;
`endif
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef CLA_SEQ_OVF_EN
  assign ovf = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < WORDS; i++) result[i*WIDTH +: WIDTH] = r_word[i];
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder (WORDS=4): directed cases plus random
// operations against a wide-arithmetic reference model.
module tb_cla_seq_adder;

  localparam int WIDTH = 16;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] op_a = '0;
  logic [N-1:0] op_b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] result;
  logic         cout;
  logic         ovf;

  int n_checks = 0;
  int n_pass   = 0;

  cla_seq_adder #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: plain wide arithmetic; overflow when the exact signed value
  // does not fit in N bits.
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic s, input logic ci,
                                output logic [N-1:0] r, output logic co, output logic ov);
    logic [N:0]          wide;
    logic signed [N+1:0] sa, sb, sc, sw;
    sa = $signed({{2{a[N-1]}}, a});
    sb = $signed({{2{b[N-1]}}, b});
    sc = $signed({{(N+1){1'b0}}, ci});
    if (!s) begin
      wide = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
      r    = wide[N-1:0];
      co   = wide[N];
      sw   = sa + sb + sc;
    end else begin
      r  = a - b - {{(N-1){1'b0}}, ci};
      co = ({1'b0, a} >= ({1'b0, b} + {{N{1'b0}}, ci}));
      sw = sa - sb - sc;
    end
`ifdef CLA_SEQ_OVF_EN
    ov = !((sw[N+1:N-1] == 3'b000) || (sw[N+1:N-1] == 3'b111));
`else
    ov = 1'b0;
`endif
  endfunction

  // Issue one operation and wait (bounded) for out_valid; leaves DUT in DONE.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic s, input logic ci,
                        input logic [N-1:0] er, input logic eco, input logic eov);
    int lat;
    @(negedge clk);
    check({tag, ".in_ready"}, in_ready, 1);
    op_a = a; op_b = b; sub = s; cin = ci; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a = '0; op_b = '0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    check({tag, ".latency"}, lat, WORDS);
    check({tag, ".result"}, result, er);
    check({tag, ".cout"}, cout, eco);
    check({tag, ".ovf"}, ovf, eov);
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".idle_ready"}, in_ready, 1);
    check({tag, ".valid_low"}, out_valid, 0);
  endtask

  initial begin
    logic [N-1:0] ra, rb, er, held;
    logic         rs, rc, eco, eov, ovf_exp;

`ifdef CLA_SEQ_OVF_EN
    ovf_exp = 1'b1;
`else
    ovf_exp = 1'b0;
`endif

    // Reset values while reset is held.
    #12;
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.result", result, 0);
    check("rst.cout", cout, 0);
    check("rst.ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("chain", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    release_out("chain");
    run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    release_out("wrap");
    run_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, ovf_exp);
    release_out("sovf");
    run_op("sub57", 64'd5, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    release_out("sub57");
    run_op("sub75", 64'd7, 64'd5, 1'b1, 1'b0, 64'd2, 1'b1, 1'b0);

    // Backpressure: DONE held, new operands offered but refused.
    held = result;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op_a = 64'h1234_5678_9ABC_DEF0; op_b = 64'h1111_1111_1111_1111;
      sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
      check("bp.out_valid", out_valid, 1);
      check("bp.in_ready", in_ready, 0);
      check("bp.result", result, held);
      check("bp.cout", cout, 1);
    end
    in_valid = 1'b0;
    release_out("bp");
    check("bp.result_kept", result, held);
    repeat (3) begin
      @(negedge clk);
      check("bp.not_taken", in_ready, 1);
    end

    // Borrow-in on subtract and carry-in on add.
    run_op("subcin", 64'd0, 64'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    release_out("subcin");
    run_op("addcin", 64'h0000_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 64'h0001_0000_0000_0000, 1'b0, 1'b0);
    release_out("addcin");

    // Random operations against the model.
    for (int t = 0; t < 24; t++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (t % 6 == 0) rb = ~ra;
      if (t % 6 == 1) ra = {1'b0, {(N-1){1'b1}}};
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      model(ra, rb, rs, rc, er, eco, eov);
      run_op($sformatf("rnd%0d", t), ra, rb, rs, rc, er, eco, eov);
      release_out($sformatf("rnd%0d", t));
    end

    // Reset mid-operation at idx==2.
    @(negedge clk);
    op_a = 64'hFFFF_FFFF_FFFF_FFFF; op_b = 64'hFFFF_FFFF_FFFF_FFFF;
    sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid.out_valid", out_valid, 0);
    check("mid.result", result, 0);
    check("mid.in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid.no_valid", out_valid, 0);
      check("mid.ready", in_ready, 1);
    end

    run_op("post", 64'd100, 64'd23, 1'b1, 1'b0, 64'd77, 1'b1, 1'b0);
    release_out("post");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
